clk_div_monitor: RTL and testbench

Receive-side checker for the divided-clock generator: samples a slow clock derived from `clk` and measures every half-period in `clk` cycles. It compares each measurement against an expected value and reports lock, per-event errors and a saturating error count. It sits beside the divider in the clock subsystem as a built-in self-check and is also usable as a bench scoreboard.

---
 rtl/clk_mon_pkg.sv | 11 +
 rtl/sync_edge_det.sv | 17 +
 rtl/clk_div_monitor.sv | 84 ++++++++
 tb/tb_clk_div_monitor.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// clk_mon_pkg: shared types and constants for the divided-clock monitor
//   mon_state_t : monitor FSM state (WAIT_EDGE, ACQ, LOCKED)
//   ERR_W       : width of the saturating error counter
package clk_mon_pkg;
   typedef enum logic [1:0] {
      WAIT_EDGE = 2'd0,
      ACQ       = 2'd1,
      LOCKED    = 2'd2
   } mon_state_t;
   localparam int ERR_W = 16;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: 2-flop synchronizer plus delay flop, flags either-polarity level changes
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   async_in : asynchronous input level
//   edg      : high for one cycle after each synchronized level change
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic edg
);
   logic s1, s2, prev;
   always_ff @(posedge clk or posedge rst)
      if (rst) {s1, s2, prev} <= 3'b000;
      else     {s1, s2, prev} <= {async_in, s1, s2};
   assign edg = s2 ^ prev;
endmodule

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures each half-period of clk_in in clk cycles and tracks lock
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   clk_in   : divided clock under test (asynchronous)
//   locked   : high while the monitor is locked
//   err      : one-cycle pulse on each lock-loss event
//   half_cnt : most recent half-period measurement
//   err_cnt  : saturating count of err pulses
module clk_div_monitor
   import clk_mon_pkg::*;
#(
   parameter int EXP_HALF = 6,
   parameter int TOL      = 0,
   parameter int LOCK_CNT = 2,
   parameter int CW       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clk_in,
   output logic             locked,
   output logic             err,
   output logic [CW-1:0]    half_cnt,
   output logic [ERR_W-1:0] err_cnt
);
   localparam logic [CW-1:0] LO = CW'(EXP_HALF - TOL);
   localparam logic [CW-1:0] HI = CW'(EXP_HALF + TOL);
   localparam int GW = $clog2(LOCK_CNT + 1);
   logic edg, in_win, tmo, good_hit, err_n;
   logic [CW-1:0] run_cnt;
   logic [GW-1:0] good, good_n;
   mon_state_t st, st_n;
   sync_edge_det u_sync (
      .clk      (clk),
      .rst      (rst),
      .async_in (clk_in),
      .edg      (edg)
   );
   assign in_win   = run_cnt >= LO && run_cnt <= HI;
   // an edge arriving on the HI count wins over the timeout
   assign tmo      = !edg && run_cnt == HI;
   assign good_hit = 32'(good) + 1 == LOCK_CNT;
   always_comb begin
      st_n   = st;
      good_n = good;
      err_n  = 1'b0;
      case (st)
         WAIT_EDGE: if (edg) begin
            st_n   = ACQ;
            good_n = '0;
         end
         ACQ: if (edg) begin
            good_n = in_win ? good + 1'b1 : '0;
            st_n   = in_win && good_hit ? LOCKED : ACQ;
         end else if (tmo) st_n = WAIT_EDGE;
         LOCKED: if (edg && !in_win) begin
            err_n  = 1'b1;
            st_n   = ACQ;
            good_n = '0;
         end else if (tmo) begin
            err_n  = 1'b1;
            st_n   = WAIT_EDGE;
         end
         default: st_n = WAIT_EDGE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         st       <= WAIT_EDGE;
         good     <= '0;
         run_cnt  <= '0;
         half_cnt <= '0;
         locked   <= 1'b0;
         err      <= 1'b0;
         err_cnt  <= '0;
      end else begin
         st       <= st_n;
         good     <= good_n;
         locked   <= st_n == LOCKED;
         err      <= err_n;
         run_cnt  <= edg ? CW'(1) : run_cnt + CW'(run_cnt != '1);
         if (edg) half_cnt <= run_cnt;
         if (err_n && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: table-driven and randomized checks of clk_div_monitor against a behavioural model
module tb_clk_div_monitor;
   typedef struct {
      int h;
      int half;
      int lck;
      int ec;
   } vec_t;
   localparam int LOCK = 2;
   logic clk, rst;
   logic cin[2];
   logic lk[2], er[2];
   logic [7:0] hc[2];
   logic [15:0] ecn[2];
   int checks = 0, failures = 0, pulses;
   int lo[2] = '{6, 5};
   int hi[2] = '{6, 7};
   vec_t ta[18];
   vec_t tv[6];
   logic [2:0] m_hist[2];
   int m_el[2], m_st[2], m_good[2], m_half[2], m_ec[2];
   logic m_err[2];
   clk_div_monitor u_a (
      .clk(clk), .rst(rst), .clk_in(cin[0]), .locked(lk[0]), .err(er[0]),
      .half_cnt(hc[0]), .err_cnt(ecn[0])
   );
   clk_div_monitor #(.TOL(1)) u_b (
      .clk(clk), .rst(rst), .clk_in(cin[1]), .locked(lk[1]), .err(er[1]),
      .half_cnt(hc[1]), .err_cnt(ecn[1])
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   // Reference: el is the number of cycles elapsed since the last detected edge,
   // an edge is a level change of clk_in seen two samples late.
   always @(posedge clk or posedge rst)
      if (rst) begin
         for (int c = 0; c < 2; c++) begin
            m_hist[c] <= 3'b000;
            m_el[c]   <= 0;
            m_st[c]   <= 0;
            m_good[c] <= 0;
            m_half[c] <= 0;
            m_err[c]  <= 1'b0;
            m_ec[c]   <= 0;
         end
      end else begin
         for (int c = 0; c < 2; c++) begin : mdl
            int el, s, g, ec;
            bit ev, win, e;
            el  = m_el[c];
            s   = m_st[c];
            g   = m_good[c];
            ec  = m_ec[c];
            e   = 1'b0;
            ev  = m_hist[c][1] ^ m_hist[c][2];
            win = el >= lo[c] && el <= hi[c];
            if (ev) begin
               m_half[c] <= el;
               if (s == 0) begin
                  s = 1;
                  g = 0;
               end else if (!win) begin
                  e = (s == 2);
                  s = 1;
                  g = 0;
               end else if (s == 1) begin
                  g++;
                  if (g == LOCK) s = 2;
               end
            end else if (el == hi[c] && s != 0) begin
               e = (s == 2);
               s = 0;
            end
            if (e && ec < 65535) ec++;
            m_el[c]   <= ev ? 1 : (el < 255 ? el + 1 : 255);
            m_st[c]   <= s;
            m_good[c] <= g;
            m_err[c]  <= e;
            m_ec[c]   <= ec;
            m_hist[c] <= {m_hist[c][1:0], cin[c]};
         end
      end
   always @(negedge clk)
      for (int c = 0; c < 2; c++) begin
         chk({c ? "B" : "A", ".locked"},   int'(lk[c]),  int'(m_st[c] == 2));
         chk({c ? "B" : "A", ".err"},      int'(er[c]),  int'(m_err[c]));
         chk({c ? "B" : "A", ".half_cnt"}, int'(hc[c]),  m_half[c]);
         chk({c ? "B" : "A", ".err_cnt"},  int'(ecn[c]), m_ec[c]);
      end
   // toggle clk_in, hold the new level for v.h cycles, check just before the next toggle
   task automatic run(input int c, input vec_t v, input string nm);
      @(negedge clk);
      cin[c] = ~cin[c];
      repeat (v.h - 1) @(negedge clk);
      if (v.half >= 0) chk({nm, ".half"}, int'(hc[c]), v.half);
      chk({nm, ".locked"},  int'(lk[c]),  v.lck);
      chk({nm, ".err_cnt"}, int'(ecn[c]), v.ec);
   endtask
   function automatic int pick();
      int r;
      r = int'($urandom_range(99, 0));
      return r < 70 ? 6 : r < 85 ? int'($urandom_range(8, 4)) : int'($urandom_range(16, 1));
   endfunction
   initial begin
      int rem[2];
      ta = '{'{6, -1, 0, 0}, '{6, 6, 0, 0}, '{6, 6, 1, 0}, '{6, 6, 1, 0},
             '{7, 6, 1, 0},  '{6, 7, 0, 1}, '{6, 6, 0, 1}, '{6, 6, 1, 1},
             '{5, 6, 1, 1},  '{6, 5, 0, 2}, '{5, 6, 0, 2}, '{6, 5, 0, 2},
             '{6, 6, 0, 2},  '{6, 6, 1, 2}, '{20, 6, 0, 3}, '{6, 20, 0, 3},
             '{6, 6, 0, 3},  '{6, 6, 1, 3}};
      tv = '{'{5, -1, 0, 0}, '{7, 5, 0, 0}, '{5, 7, 1, 0}, '{7, 5, 1, 0},
             '{8, 7, 1, 0},  '{6, 8, 0, 1}};
      rst    = 1'b1;
      cin[0] = 1'b0;
      cin[1] = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.locked",   int'(lk[0]),  0);
      chk("reset.err",      int'(er[0]),  0);
      chk("reset.half_cnt", int'(hc[0]),  0);
      chk("reset.err_cnt",  int'(ecn[0]), 0);
      #2 rst = 1'b0;
      for (int i = 0; i < 18; i++) run(0, ta[i], $sformatf("row%0d", i));
      @(posedge clk);
      #2 rst = 1'b1;
      cin[0] = 1'b0;
      #1;
      chk("midrst.locked",   int'(lk[0]),  0);
      chk("midrst.err",      int'(er[0]),  0);
      chk("midrst.half_cnt", int'(hc[0]),  0);
      chk("midrst.err_cnt",  int'(ecn[0]), 0);
      @(negedge clk);
      #2 rst = 1'b0;
      for (int i = 0; i < 3; i++) run(0, ta[i], $sformatf("relock%0d", i));
      pulses = 0;
      repeat (100) begin
         @(negedge clk);
         if (er[0]) pulses++;
      end
      chk("freeze.pulses",  pulses,       1);
      chk("freeze.err_cnt", int'(ecn[0]), 1);
      chk("freeze.locked",  int'(lk[0]),  0);
      for (int i = 0; i < 6; i++) run(1, tv[i], $sformatf("tol%0d", i));
      rem = '{1, 1};
      for (int k = 0; k < 3000; k++) begin
         @(negedge clk);
         for (int c = 0; c < 2; c++) begin
            rem[c]--;
            if (rem[c] == 0) begin
               cin[c] = ~cin[c];
               rem[c] = pick();
            end
         end
         if (k == 1500) #2 rst = 1'b1;
         if (k == 1503) #2 rst = 1'b0;
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
